// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if
//   Bundles the ID-stage hazard request, the pipeline stage destinations, the
//   long-op issue/completion bus and the forwarding/stall results.
//   master : pipeline side (drives requests, receives selects/stall/status)
//   slave  : fwd_scoreboard side
interface fwd_scoreboard_if #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 3,
  parameter int NUM_RD  = 2,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16
);
  localparam int SEL_W = $clog2(NUM_SRC + 2);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  logic [NUM_RD*AW-1:0]     rs_addr_i;
  logic [NUM_RD-1:0]        rs_used_i;
  logic [AW-1:0]            wr_addr_i;
  logic                     wr_used_i;
  logic [NUM_SRC*AW-1:0]    st_rd_i;
  logic [NUM_SRC-1:0]       st_we_i;
  logic [NUM_SRC-1:0]       st_rdy_i;
  logic                     lop_issue_i;
  logic                     lop_done_i;
  logic [AW-1:0]            lop_done_rd_i;
  logic                     flush_i;
  logic [NUM_RD*SEL_W-1:0]  fwd_sel_o;
  logic                     stall_o;
  logic [OUT_W-1:0]         outstanding_o;
  logic [CNT_W-1:0]         stall_cnt_o;
  logic                     timeout_o;
  logic                     err_o;

  modport master (
    output rs_addr_i, rs_used_i, wr_addr_i, wr_used_i, st_rd_i, st_we_i,
           st_rdy_i, lop_issue_i, lop_done_i, lop_done_rd_i, flush_i,
    input  fwd_sel_o, stall_o, outstanding_o, stall_cnt_o, timeout_o, err_o
  );

  modport slave (
    input  rs_addr_i, rs_used_i, wr_addr_i, wr_used_i, st_rd_i, st_we_i,
           st_rdy_i, lop_issue_i, lop_done_i, lop_done_rd_i, flush_i,
    output fwd_sel_o, stall_o, outstanding_o, stall_cnt_o, timeout_o, err_o
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Forwarding and hazard unit for the ID stage. Picks a bypass source per
//   read port (regfile, pipeline stage k, or the long-op completion bus),
//   raises a single ID stall for load-use, RAW/WAW against outstanding long
//   ops and a full scoreboard, and keeps stall statistics, a stall watchdog
//   and a sticky protocol-error flag.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fwd_scoreboard_if.slave (requests in, selects/stall/status out)
module fwd_scoreboard #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 3,
  parameter int NUM_RD  = 2,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  fwd_scoreboard_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_SRC + 2);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int NREG  = 1 << AW;

  logic [NREG-1:0]  busy_q, busy_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic             err_q, err_d;

  logic [NUM_RD*SEL_W-1:0] fwd_sel;
  logic [NUM_RD-1:0]       port_haz;
  logic [AW-1:0]           rd_addr;
  logic                    hit;
  logic                    waw_haz, struct_haz, stall;
  logic                    done_eff, issue_eff, inc, dec;

  // Bypass selection: youngest matching stage wins and hides everything older.
  always_comb begin
    fwd_sel  = '0;
    port_haz = '0;
    rd_addr  = '0;
    hit      = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr = bus.rs_addr_i[p*AW +: AW];
      hit     = 1'b0;
      if (bus.rs_used_i[p] && rd_addr != '0) begin
        for (int k = 0; k < NUM_SRC; k++) begin
          if (!hit && bus.st_we_i[k] && bus.st_rd_i[k*AW +: AW] == rd_addr &&
              bus.st_rd_i[k*AW +: AW] != '0) begin
            hit = 1'b1;
            fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
            if (!bus.st_rdy_i[k]) port_haz[p] = 1'b1;
          end
        end
        if (!hit) begin
          if (bus.lop_done_i && bus.lop_done_rd_i == rd_addr)
            fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(NUM_SRC + 1);
          else if (busy_q[rd_addr])
            port_haz[p] = 1'b1;
        end
      end
    end
  end

  // A completion that frees a slot this cycle relieves both WAW and full stalls.
  always_comb begin
    waw_haz    = bus.wr_used_i && bus.wr_addr_i != '0 && busy_q[bus.wr_addr_i] &&
                 !(bus.lop_done_i && bus.lop_done_rd_i == bus.wr_addr_i);
    struct_haz = bus.lop_issue_i && out_q == OUT_W'(MAX_OUT) &&
                 !(bus.lop_done_i && busy_q[bus.lop_done_rd_i]);
    stall      = (|port_haz) || waw_haz || struct_haz;
  end

  always_comb begin
    busy_d      = busy_q;
    out_d       = out_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    wd_d        = '0;
    done_eff    = bus.lop_done_i && bus.lop_done_rd_i != '0 && busy_q[bus.lop_done_rd_i];
    issue_eff   = bus.lop_issue_i && !stall && !bus.flush_i && bus.wr_addr_i != '0;
    // Only a 0->1 transition counts; a set that overrides a same-cycle clear
    // also counts so it balances the clear.
    inc         = issue_eff && (!busy_q[bus.wr_addr_i] ||
                                (done_eff && bus.lop_done_rd_i == bus.wr_addr_i));
    dec         = done_eff;

    if (done_eff)  busy_d[bus.lop_done_rd_i] = 1'b0;
    if (issue_eff) busy_d[bus.wr_addr_i]     = 1'b1;

    if (inc && !dec)      out_d = out_q + 1'b1;
    else if (dec && !inc) out_d = out_q - 1'b1;

    if (bus.lop_done_i && (bus.lop_done_rd_i == '0 || !busy_q[bus.lop_done_rd_i]))
      err_d = 1'b1;
    if (bus.lop_issue_i && !bus.wr_used_i)
      err_d = 1'b1;

    if (stall && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;

    if (stall)
      wd_d = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + 1'b1;
    timeout_d = timeout_q || (wd_d == WD_W'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      out_q       <= '0;
      stall_cnt_q <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_q       <= out_d;
      stall_cnt_q <= stall_cnt_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  assign bus.fwd_sel_o     = fwd_sel;
  assign bus.stall_o       = stall;
  assign bus.outstanding_o = out_q;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.timeout_o     = timeout_q;
  assign bus.err_o         = err_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard. Inputs change on the falling edge;
// combinational results are sampled 1ns later, registered results on the
// following falling edge.
module tb_fwd_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  fwd_scoreboard_if bus ();
  fwd_scoreboard dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic set_defaults();
    bus.rs_addr_i     = '0;
    bus.rs_used_i     = '0;
    bus.wr_addr_i     = '0;
    bus.wr_used_i     = 1'b0;
    bus.st_rd_i       = '0;
    bus.st_we_i       = '0;
    bus.st_rdy_i      = '0;
    bus.lop_issue_i   = 1'b0;
    bus.lop_done_i    = 1'b0;
    bus.lop_done_rd_i = '0;
    bus.flush_i       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_defaults();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++;
    if (bus.outstanding_o !== 3'd0) begin tests_failed++; $display("FAIL reset_out got %0d want 0", bus.outstanding_o); end
    tests_run++;
    if (bus.stall_cnt_o !== 16'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d want 0", bus.stall_cnt_o); end
    tests_run++;
    if (bus.timeout_o !== 1'b0 || bus.err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_flags got to=%b err=%b want 0 0", bus.timeout_o, bus.err_o); end
    tests_run++;
    if (bus.stall_o !== 1'b0 || bus.fwd_sel_o !== 6'd0) begin tests_failed++; $display("FAIL reset_comb got stall=%b sel=%h want 0 0", bus.stall_o, bus.fwd_sel_o); end
  endtask

  task automatic test_stage_priority();
    @(negedge clk);
    set_defaults();
    bus.st_we_i = 3'b111; bus.st_rd_i = {5'd5, 5'd5, 5'd5}; bus.st_rdy_i = 3'b111;
    bus.rs_used_i = 2'b01; bus.rs_addr_i = {5'd0, 5'd5};
    #1;
    tests_run++;
    if (bus.fwd_sel_o[2:0] !== 3'd1 || bus.stall_o !== 1'b0) begin tests_failed++; $display("FAIL prio_s0 got sel=%0d stall=%b want 1 0", bus.fwd_sel_o[2:0], bus.stall_o); end
    bus.st_we_i = 3'b110;
    #1;
    tests_run++;
    if (bus.fwd_sel_o[2:0] !== 3'd2) begin tests_failed++; $display("FAIL prio_s1 got %0d want 2", bus.fwd_sel_o[2:0]); end
    bus.st_we_i = 3'b100;
    #1;
    tests_run++;
    if (bus.fwd_sel_o[2:0] !== 3'd3) begin tests_failed++; $display("FAIL prio_s2 got %0d want 3", bus.fwd_sel_o[2:0]); end
    bus.st_we_i = 3'b111; bus.st_rd_i = '0; bus.rs_addr_i = '0;
    #1;
    tests_run++;
    if (bus.fwd_sel_o[2:0] !== 3'd0) begin tests_failed++; $display("FAIL prio_x0 got %0d want 0", bus.fwd_sel_o[2:0]); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_defaults();
    bus.st_rd_i = {5'd0, 5'd0, 5'd7}; bus.st_we_i = 3'b001; bus.st_rdy_i = 3'b000;
    bus.rs_used_i = 2'b10; bus.rs_addr_i = {5'd7, 5'd0};
    #1;
    tests_run++;
    if (bus.stall_o !== 1'b1 || bus.fwd_sel_o[5:3] !== 3'd1) begin tests_failed++; $display("FAIL lu_stall got stall=%b sel1=%0d want 1 1", bus.stall_o, bus.fwd_sel_o[5:3]); end
    @(negedge clk);
    bus.st_rdy_i = 3'b001;
    #1;
    tests_run++;
    if (bus.stall_o !== 1'b0) begin tests_failed++; $display("FAIL lu_release got %b want 0", bus.stall_o); end
    @(negedge clk);
    tests_run++;
    if (bus.stall_cnt_o !== 16'd1) begin tests_failed++; $display("FAIL lu_cnt got %0d want 1", bus.stall_cnt_o); end
  endtask

  task automatic test_long_op();
    @(negedge clk);
    set_defaults();
    bus.wr_addr_i = 5'd9; bus.wr_used_i = 1'b1; bus.lop_issue_i = 1'b1;
    #1;
    tests_run++;
    if (bus.stall_o !== 1'b0) begin tests_failed++; $display("FAIL lop_issue_stall got %b want 0", bus.stall_o); end
    @(negedge clk);
    set_defaults();
    #1;
    tests_run++;
    if (bus.outstanding_o !== 3'd1) begin tests_failed++; $display("FAIL lop_out1 got %0d want 1", bus.outstanding_o); end
    bus.rs_used_i = 2'b01; bus.rs_addr_i = {5'd0, 5'd9};
    #1;
    tests_run++;
    if (bus.stall_o !== 1'b1 || bus.fwd_sel_o[2:0] !== 3'd0) begin tests_failed++; $display("FAIL lop_raw got stall=%b sel=%0d want 1 0", bus.stall_o, bus.fwd_sel_o[2:0]); end
    @(negedge clk);
    bus.lop_done_i = 1'b1; bus.lop_done_rd_i = 5'd9;
    #1;
    tests_run++;
    if (bus.stall_o !== 1'b0 || bus.fwd_sel_o[2:0] !== 3'd4) begin tests_failed++; $display("FAIL lop_bypass got stall=%b sel=%0d want 0 4", bus.stall_o, bus.fwd_sel_o[2:0]); end
    @(negedge clk);
    set_defaults();
    #1;
    tests_run++;
    if (bus.outstanding_o !== 3'd0 || bus.stall_cnt_o !== 16'd2 || bus.err_o !== 1'b0) begin tests_failed++; $display("FAIL lop_retire got out=%0d cnt=%0d err=%b want 0 2 0", bus.outstanding_o, bus.stall_cnt_o, bus.err_o); end
  endtask

  task automatic test_structural();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      set_defaults();
      bus.wr_addr_i = 5'(i); bus.wr_used_i = 1'b1; bus.lop_issue_i = 1'b1;
    end
    @(negedge clk);
    set_defaults();
    #1;
    tests_run++;
    if (bus.outstanding_o !== 3'd4) begin tests_failed++; $display("FAIL st_full got %0d want 4", bus.outstanding_o); end
    bus.wr_addr_i = 5'd6; bus.wr_used_i = 1'b1; bus.lop_issue_i = 1'b1;
    #1;
    tests_run++;
    if (bus.stall_o !== 1'b1) begin tests_failed++; $display("FAIL st_stall got %b want 1", bus.stall_o); end
    bus.lop_done_i = 1'b1; bus.lop_done_rd_i = 5'd1;
    #1;
    tests_run++;
    if (bus.stall_o !== 1'b0) begin tests_failed++; $display("FAIL st_relief got %b want 0", bus.stall_o); end
    @(negedge clk);
    set_defaults();
    bus.rs_used_i = 2'b01; bus.rs_addr_i = {5'd0, 5'd6};
    #1;
    tests_run++;
    if (bus.outstanding_o !== 3'd4 || bus.stall_o !== 1'b1) begin tests_failed++; $display("FAIL st_x6 got out=%0d stall=%b want 4 1", bus.outstanding_o, bus.stall_o); end
    bus.rs_addr_i = {5'd0, 5'd1};
    #1;
    tests_run++;
    if (bus.stall_o !== 1'b0 || bus.err_o !== 1'b0) begin tests_failed++; $display("FAIL st_x1 got stall=%b err=%b want 0 0", bus.stall_o, bus.err_o); end
  endtask

  task automatic test_error_flush();
    do_reset();
    bus.lop_done_i = 1'b1; bus.lop_done_rd_i = 5'd12;
    @(negedge clk);
    set_defaults();
    #1;
    tests_run++;
    if (bus.err_o !== 1'b1 || bus.outstanding_o !== 3'd0) begin tests_failed++; $display("FAIL err_done got err=%b out=%0d want 1 0", bus.err_o, bus.outstanding_o); end
    bus.wr_addr_i = 5'd13; bus.wr_used_i = 1'b1; bus.lop_issue_i = 1'b1; bus.flush_i = 1'b1;
    @(negedge clk);
    set_defaults();
    bus.rs_used_i = 2'b10; bus.rs_addr_i = {5'd13, 5'd0};
    #1;
    tests_run++;
    if (bus.outstanding_o !== 3'd0 || bus.stall_o !== 1'b0) begin tests_failed++; $display("FAIL flush got out=%0d stall=%b want 0 0", bus.outstanding_o, bus.stall_o); end
    set_defaults();
    bus.wr_addr_i = 5'd14; bus.wr_used_i = 1'b1; bus.lop_issue_i = 1'b1;
    @(negedge clk);
    set_defaults();
    #1;
    tests_run++;
    if (bus.outstanding_o !== 3'd1) begin tests_failed++; $display("FAIL pre_rst got %0d want 1", bus.outstanding_o); end
    do_reset();
    bus.rs_used_i = 2'b01; bus.rs_addr_i = {5'd0, 5'd14};
    #1;
    tests_run++;
    if (bus.err_o !== 1'b0 || bus.outstanding_o !== 3'd0 || bus.stall_o !== 1'b0) begin tests_failed++; $display("FAIL rst_clear got err=%b out=%0d stall=%b want 0 0 0", bus.err_o, bus.outstanding_o, bus.stall_o); end
    set_defaults();
    bus.wr_addr_i = 5'd15; bus.wr_used_i = 1'b0; bus.lop_issue_i = 1'b1;
    @(negedge clk);
    set_defaults();
    #1;
    tests_run++;
    if (bus.err_o !== 1'b1) begin tests_failed++; $display("FAIL err_issue got %b want 1", bus.err_o); end
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.wr_addr_i = 5'd9; bus.wr_used_i = 1'b1; bus.lop_issue_i = 1'b1;
    @(negedge clk);
    set_defaults();
    bus.rs_used_i = 2'b01; bus.rs_addr_i = {5'd0, 5'd9};
    repeat (255) @(negedge clk);
    #1;
    tests_run++;
    if (bus.timeout_o !== 1'b0) begin tests_failed++; $display("FAIL wd_early got %b want 0", bus.timeout_o); end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.timeout_o !== 1'b1 || bus.stall_cnt_o !== 16'd256) begin tests_failed++; $display("FAIL wd_trip got to=%b cnt=%0d want 1 256", bus.timeout_o, bus.stall_cnt_o); end
    set_defaults();
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (bus.timeout_o !== 1'b1 || bus.stall_o !== 1'b0) begin tests_failed++; $display("FAIL wd_sticky got to=%b stall=%b want 1 0", bus.timeout_o, bus.stall_o); end
    do_reset();
    #1;
    tests_run++;
    if (bus.timeout_o !== 1'b0) begin tests_failed++; $display("FAIL wd_rst got %b want 0", bus.timeout_o); end
  endtask

  initial begin
    set_defaults();
    test_reset();
    test_stage_priority();
    test_load_use();
    test_long_op();
    test_structural();
    test_error_flush();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
